// File: rtl/sliding_window_gen.sv
// Streaming KxK window generator: K-1 line buffers feed a KxK register window that emits one
// flattened window per valid top-left position of a raster-order frame, with ready/valid flow.
module sliding_window_gen #(
    parameter int unsigned IMG_W = 512,
    parameter int unsigned IMG_H = 512,
    parameter int unsigned K     = 5,
    parameter int unsigned PIX_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIX_W-1:0]         in_pix,
    input  logic                     in_sof,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [K*K*PIX_W-1:0]     out_win,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     frame_done,
    output logic                     sof_err
);

    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W);

    typedef enum logic [1:0] {StWaitSof, StFill, StStream, StWaitDrain} state_e;

    state_e           r_state;
    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [PIX_W-1:0] r_lb  [K-1][IMG_W];
    logic [PIX_W-1:0] r_win [K][K];
    logic             r_out_valid;
    logic             r_sof_err;
    logic [RW-1:0]    r_out_row;
    logic [CW-1:0]    r_out_col;

    logic             w_acc;
    logic             w_retire;
    logic             w_start;
    logic             w_sof_err;
    logic             w_frame_pix;
    logic             w_stream_pix;
    logic             w_emit;
    logic             w_last;
    logic [RW-1:0]    w_prow;
    logic [CW-1:0]    w_pcol;
    logic [PIX_W-1:0] w_col [K];

    assign in_ready   = rst && (r_state != StWaitDrain) && (!r_out_valid || out_ready);
    assign w_acc      = in_valid && in_ready;
    assign w_retire   = r_out_valid && out_ready;
    assign w_start    = w_acc && in_sof;
    assign w_sof_err  = w_start && (r_state != StWaitSof) && ((r_row != '0) || (r_col != '0));
    assign w_frame_pix = w_acc && (in_sof || (r_state != StWaitSof));
    // A start-of-frame pixel always lands at (0,0), whatever the counters say.
    assign w_prow     = w_start ? '0 : r_row;
    assign w_pcol     = w_start ? '0 : r_col;
    assign w_stream_pix = w_frame_pix && !in_sof &&
                          ((r_state == StStream) || ((r_state == StFill) && (r_row == RW'(K-1))));
    assign w_emit     = w_stream_pix && (r_col >= CW'(K-1));
    assign w_last     = w_stream_pix && (r_row == RW'(IMG_H-1)) && (r_col == CW'(IMG_W-1));

    assign frame_done = (r_state == StWaitDrain) && w_retire;
    assign sof_err    = r_sof_err;
    assign out_valid  = r_out_valid;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;

    // Column entering the window: buffered rows oldest-first, then the live pixel.
    always_comb begin
        for (int i = 0; i < K-1; i++) begin
            w_col[i] = r_lb[i][w_pcol];
        end
        w_col[K-1] = in_pix;
    end

    always_comb begin
        out_win = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                out_win[(r*K+c)*PIX_W +: PIX_W] = r_win[r][c];
            end
        end
    end

    // Each line buffer column ages by one row per write; read happens before the write.
    always_ff @(posedge clk) begin
        if (w_frame_pix) begin
            for (int j = 0; j < K-1; j++) begin
                r_lb[j][w_pcol] <= w_col[j+1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StWaitSof;
            r_row       <= '0;
            r_col       <= '0;
            r_out_valid <= 1'b0;
            r_sof_err   <= 1'b0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            r_sof_err <= w_sof_err;

            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_row   <= r_row - RW'(K-1);
                r_out_col   <= r_col - CW'(K-1);
            end else if (w_retire || w_sof_err) begin
                r_out_valid <= 1'b0;
            end

            if (w_stream_pix) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K-1; c++) begin
                        r_win[r][c] <= r_win[r][c+1];
                    end
                    r_win[r][K-1] <= w_col[r];
                end
            end

            if (w_frame_pix) begin
                if (w_last) begin
                    r_row   <= '0;
                    r_col   <= '0;
                    r_state <= StWaitDrain;
                end else begin
                    if (w_pcol == CW'(IMG_W-1)) begin
                        r_col <= '0;
                        r_row <= w_prow + RW'(1);
                    end else begin
                        r_col <= w_pcol + CW'(1);
                        r_row <= w_prow;
                    end
                    if (w_start) begin
                        r_state <= StFill;
                    end else if (w_stream_pix) begin
                        r_state <= StStream;
                    end
                end
            end else if ((r_state == StWaitDrain) && w_retire) begin
                r_state <= StWaitSof;
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Bench for sliding_window_gen: a frame-image reference model predicts every window, plus
// fixed expectations for the basic stream and hand-built early-sof / mid-frame-reset sequences.
module tb_sliding_window_gen;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int K     = 3;
    localparam int PIX_W = 10;
    localparam int WW    = K*K*PIX_W;
    localparam int NWIN  = (IMG_W-K+1)*(IMG_H-K+1);

    logic                     clk;
    logic                     rst;
    logic [PIX_W-1:0]         in_pix;
    logic                     in_sof;
    logic                     in_valid;
    logic                     in_ready;
    logic [WW-1:0]            out_win;
    logic [$clog2(IMG_H)-1:0] out_row;
    logic [$clog2(IMG_W)-1:0] out_col;
    logic                     out_valid;
    logic                     out_ready;
    logic                     frame_done;
    logic                     sof_err;

    sliding_window_gen #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PIX_W(PIX_W)
    ) dut (
        .clk(clk), .rst(rst), .in_pix(in_pix), .in_sof(in_sof), .in_valid(in_valid),
        .in_ready(in_ready), .out_win(out_win), .out_row(out_row), .out_col(out_col),
        .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done),
        .sof_err(sof_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int row;
        int col;
        int e00;
        int e11;
        int e22;
    } vec_t;
    vec_t tbl[5];

    int n_total, n_bad;

    // Reference model: pixel index within the current frame and the frame image itself.
    logic [PIX_W-1:0] img [IMG_H][IMG_W];
    logic             m_valid, m_drain, m_active, m_sof_err;
    int               m_n, m_row, m_col;
    logic [WW-1:0]    m_win;

    logic [WW-1:0] cap_win [64];
    int            cap_row [64];
    int            cap_col [64];
    int            cap_n, n_fd, n_se, first_n, n_rdy_low;
    int            p_valid, p_ready, bp_left;
    bit            bp_arm;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic s, input logic [PIX_W-1:0] p, input logic o,
                       input logic rn, output logic acc);
        logic exp_rdy, retire, err, nv;
        int   r, c;
        in_valid  = v;
        in_sof    = s;
        in_pix    = p;
        out_ready = o;
        rst       = rn;
        @(negedge clk);
        exp_rdy = rn && !m_drain && (!m_valid || o);
        chk("in_ready", WW'(in_ready), WW'(exp_rdy));
        chk("out_valid", WW'(out_valid), WW'(m_valid));
        chk("frame_done", WW'(frame_done), WW'(m_drain && m_valid && o));
        chk("sof_err", WW'(sof_err), WW'(m_sof_err));
        if (m_valid) begin
            chk("out_row", WW'(out_row), WW'(m_row));
            chk("out_col", WW'(out_col), WW'(m_col));
            chk("out_win", out_win, m_win);
        end
        if (out_valid === 1'b1 && o === 1'b1) begin
            if (cap_n < 64) begin
                cap_win[cap_n] = out_win;
                cap_row[cap_n] = int'(out_row);
                cap_col[cap_n] = int'(out_col);
            end
            cap_n++;
        end
        if (frame_done === 1'b1) n_fd++;
        if (sof_err === 1'b1) n_se++;
        if (out_valid === 1'b1 && first_n < 0) first_n = m_n;
        if (v && rn && in_ready === 1'b0) n_rdy_low++;

        acc = 1'b0;
        if (!rn) begin
            m_valid = 0; m_drain = 0; m_active = 0; m_n = 0; m_sof_err = 0;
        end else begin
            acc    = v && exp_rdy;
            retire = m_valid && o;
            nv     = m_valid && !retire;
            err    = 1'b0;
            if (retire && m_drain) m_drain = 1'b0;
            if (acc) begin
                if (s) begin
                    err      = m_active && (m_n != 0);
                    m_active = 1'b1;
                    m_n      = 0;
                end
                if (m_active) begin
                    r = m_n / IMG_W;
                    c = m_n % IMG_W;
                    img[r][c] = p;
                    m_n++;
                    if (r >= K-1 && c >= K-1) begin
                        nv    = 1'b1;
                        m_row = r-K+1;
                        m_col = c-K+1;
                        for (int i = 0; i < K; i++)
                            for (int j = 0; j < K; j++)
                                m_win[(i*K+j)*PIX_W +: PIX_W] = img[m_row+i][m_col+j];
                    end
                    if (err) nv = 1'b0;
                    if (m_n == IMG_W*IMG_H) begin
                        m_active = 1'b0;
                        m_drain  = 1'b1;
                        m_n      = 0;
                    end
                end
            end
            m_valid   = nv;
            m_sof_err = err;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic [PIX_W-1:0] p);
        logic acc, v, o;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            if (bp_arm && m_valid && m_row == 0 && m_col == 4) begin
                bp_left = 7;
                bp_arm  = 0;
            end
            v = ($urandom_range(99) < p_valid);
            if (bp_left > 0) begin
                o = 1'b0;
                bp_left--;
            end else begin
                o = ($urandom_range(99) < p_ready);
            end
            cyc(v, s, p, o, 1'b1, acc);
            tries++;
        end
        if (!acc) begin
            n_total++;
            n_bad++;
            $display("FAIL send_timeout: got no acceptance want acceptance");
        end
    endtask

    task automatic drain();
        logic acc;
        int   t;
        t = 0;
        while ((m_valid || m_drain) && t < 100) begin
            cyc(1'b0, 1'b0, '0, ($urandom_range(99) < p_ready), 1'b1, acc);
            t++;
        end
        if (m_valid || m_drain) begin
            n_total++;
            n_bad++;
            $display("FAIL drain_timeout: got window pending want drained");
        end
    endtask

    task automatic frame(input int restart_at, input bit rnd);
        int               n;
        bit               restarted;
        logic [PIX_W-1:0] p;
        n = 0;
        restarted = 0;
        while (n < IMG_W*IMG_H) begin
            if (!restarted && n == restart_at) begin
                restarted = 1;
                n = 0;
            end
            p = rnd ? PIX_W'($urandom)
                    : PIX_W'((n/IMG_W)*16 + n%IMG_W + (restarted ? 256 : 0));
            send(n == 0, p);
            n++;
        end
    endtask

    task automatic begin_scn();
        cap_n = 0; n_fd = 0; n_se = 0; first_n = -1; n_rdy_low = 0;
    endtask

    task automatic check_table(input string tag);
        logic [WW-1:0] w;
        for (int i = 0; i < 5; i++) begin
            w = cap_win[tbl[i].idx];
            chk({tag, "_row"}, WW'(cap_row[tbl[i].idx]), WW'(tbl[i].row));
            chk({tag, "_col"}, WW'(cap_col[tbl[i].idx]), WW'(tbl[i].col));
            chk({tag, "_e00"}, WW'(w[0 +: PIX_W]), WW'(tbl[i].e00));
            chk({tag, "_e11"}, WW'(w[4*PIX_W +: PIX_W]), WW'(tbl[i].e11));
            chk({tag, "_e22"}, WW'(w[8*PIX_W +: PIX_W]), WW'(tbl[i].e22));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic          acc;
        int            ra, prior;
        logic [WW-1:0] w;

        tbl[0] = '{0,  0, 0, 'h00, 'h11, 'h22};
        tbl[1] = '{4,  0, 4, 'h04, 'h15, 'h26};
        tbl[2] = '{5,  0, 5, 'h05, 'h16, 'h27};
        tbl[3] = '{6,  1, 0, 'h10, 'h21, 'h32};
        tbl[4] = '{23, 3, 5, 'h35, 'h46, 'h57};

        n_total = 0; n_bad = 0;
        p_valid = 100; p_ready = 100; bp_arm = 0; bp_left = 0;
        m_valid = 0; m_drain = 0; m_active = 0; m_sof_err = 0; m_n = 0; m_row = 0; m_col = 0;
        m_win = '0;
        begin_scn();

        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b1, '0, 1'b1, 1'b0, acc);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);
        chk("rst_row", WW'(out_row), '0);
        chk("rst_col", WW'(out_col), '0);
        chk("rst_win", out_win, '0);

        // Basic stream.
        begin_scn();
        frame(-1, 0);
        drain();
        chk("basic_first_latency", WW'(first_n), WW'(19));
        chk("basic_count", WW'(cap_n), WW'(NWIN));
        chk("basic_done", WW'(n_fd), WW'(1));
        chk("basic_stalls", WW'(n_rdy_low), WW'(0));
        check_table("basic");

        // Garbage before sof is discarded.
        begin_scn();
        for (int i = 0; i < 10; i++) send(1'b0, PIX_W'($urandom));
        frame(-1, 0);
        drain();
        chk("garb_count", WW'(cap_n), WW'(NWIN));
        chk("garb_done", WW'(n_fd), WW'(1));
        check_table("garb");

        // Backpressure for 7 cycles at window (0,4).
        begin_scn();
        bp_arm = 1;
        frame(-1, 0);
        drain();
        chk("bp_count", WW'(cap_n), WW'(NWIN));
        chk("bp_done", WW'(n_fd), WW'(1));
        chk("bp_stalls", WW'(n_rdy_low), WW'(7));
        check_table("bp");

        // Early sof at pixel (3,4).
        begin_scn();
        frame(3*IMG_W+4, 0);
        drain();
        chk("esof_err", WW'(n_se), WW'(1));
        chk("esof_count", WW'(cap_n), WW'(8+NWIN));
        chk("esof_done", WW'(n_fd), WW'(1));
        w = cap_win[8];
        chk("esof_row", WW'(cap_row[8]), '0);
        chk("esof_col", WW'(cap_col[8]), '0);
        chk("esof_e00", WW'(w[0 +: PIX_W]), WW'('h100));
        chk("esof_e22", WW'(w[8*PIX_W +: PIX_W]), WW'('h122));

        // Reset while a window is held under backpressure.
        begin_scn();
        for (int n = 0; n < 19; n++) send(n == 0, PIX_W'((n/IMG_W)*16 + n%IMG_W));
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", WW'(out_valid), '0);
        chk("rstmid_ready", WW'(in_ready), WW'(1));
        for (int i = 0; i < 19; i++) send(1'b0, PIX_W'($urandom));
        chk("rstmid_nowin", WW'(cap_n), '0);
        frame(-1, 0);
        drain();
        chk("rstmid_count", WW'(cap_n), WW'(NWIN));
        chk("rstmid_done", WW'(n_fd), WW'(1));

        // Random data and random stalls on both sides.
        begin_scn();
        p_valid = 80;
        p_ready = 70;
        ra = $urandom_range(40, 5);
        prior = 0;
        for (int i = 0; i < ra; i++)
            if (i/IMG_W >= K-1 && i%IMG_W >= K-1) prior++;
        for (int f = 0; f < 4; f++) begin
            repeat ($urandom_range(3)) send(1'b0, PIX_W'($urandom));
            frame((f == 2) ? ra : -1, 1);
            drain();
        end
        chk("rand_done", WW'(n_fd), WW'(4));
        chk("rand_err", WW'(n_se), WW'(1));
        chk("rand_count", WW'(cap_n), WW'(4*NWIN + prior));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
